// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract accumulator.
//   ADDSUB_WIDTH : default operand/accumulator width
//   ADDSUB_SMAX  : most positive signed value at ADDSUB_WIDTH
//   ADDSUB_SMIN  : most negative signed value at ADDSUB_WIDTH
//   state_t      : accumulator control states (IDLE, RUN, DONE)
package addsub_pkg;

    localparam int unsigned ADDSUB_WIDTH = 4;

    localparam logic [ADDSUB_WIDTH-1:0] ADDSUB_SMAX = {1'b0, {(ADDSUB_WIDTH-1){1'b1}}};
    localparam logic [ADDSUB_WIDTH-1:0] ADDSUB_SMIN = {1'b1, {(ADDSUB_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit two's-complement adder/subtractor with overflow.
// Ports:
//   a, b      : signed operands
//   sel       : 0 -> a + b, 1 -> a - b
//   result    : low WIDTH bits of the exact result (wraps)
//   overflow  : signed overflow of this single operation
module addsub_core
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = ADDSUB_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    logic sa;
    logic sb;
    logic sr;

    assign result = sel ? (a - b) : (a + b);

    assign sa = a[WIDTH-1];
    assign sb = b[WIDTH-1];
    assign sr = result[WIDTH-1];

    // Add overflows when like signs give an unlike result; subtract when
    // unlike signs give a result whose sign departs from the minuend.
    assign overflow = sel ? ((sa != sb) && (sr != sa))
                          : ((sa == sb) && (sr != sa));

endmodule

// File: rtl/addsub_accumulator.sv
// Burst accumulator: takes a counted burst of signed operands over a
// valid/ready handshake, adds/subtracts each into a running total via
// addsub_core, then presents the total and a sticky overflow flag.
// Optional macro ADDSUB_ACC_SATURATE_EN: clamp the total on overflow
// instead of wrapping.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, len          : begin a burst of len operands (sampled in IDLE)
//   in_valid, in_ready  : operand handshake
//   in_data, in_sub     : operand and add(0)/subtract(1) select
//   out_valid, out_ready: result handshake
//   out_sum, out_ovf    : accumulated total and sticky overflow
//   busy                : state is not IDLE
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = ADDSUB_WIDTH,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy
);

`ifdef ADDSUB_ACC_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] rem_q, rem_d;

    logic [WIDTH-1:0] core_result;
    logic             core_ovf;
    logic [WIDTH-1:0] step_val;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a        (acc_q),
        .b        (in_data),
        .sel      (in_sub),
        .result   (core_result),
        .overflow (core_ovf)
    );

    // Value the accumulator takes on an accepted operand.
`ifdef ADDSUB_ACC_SATURATE_EN
    // On overflow the true result lies beyond the accumulator's side of
    // zero, so the clamp direction follows the sign of the old total.
    assign step_val = core_ovf ? (acc_q[WIDTH-1] ? SAT_MIN : SAT_MAX) : core_result;
`else
    assign step_val = core_result;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    rem_d   = len;
                    state_d = (len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_valid) begin
                    acc_d = step_val;
                    ovf_d = ovf_q | core_ovf;
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Handshake flags decode only from the registered state.
    assign in_ready  = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed self-checking bench for addsub_accumulator (WIDTH=4, CNT_W=4).
// Honours ADDSUB_ACC_SATURATE_EN for the saturating expectations.
module tb_addsub_accumulator;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       in_sub;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sum;
    logic       out_ovf;
    logic       busy;

    int checks;
    int passes;

`ifdef ADDSUB_ACC_SATURATE_EN
    localparam logic [3:0] EXP_T1 = 4'b0111;
    localparam logic [3:0] EXP_T3 = 4'b0110;
    localparam logic [3:0] EXP_T4 = 4'b0111;
`else
    localparam logic [3:0] EXP_T1 = 4'b1000;
    localparam logic [3:0] EXP_T3 = 4'b0111;
    localparam logic [3:0] EXP_T4 = 4'b1000;
`endif

    addsub_accumulator #(.WIDTH(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
        len   = 4'd0;
    endtask

    task automatic send(input logic [3:0] d, input logic sub);
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = sub;
        tick();
        in_valid = 1'b0;
        in_data  = 4'd0;
        in_sub   = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", in_ready); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (out_sum !== 4'b0000) $display("FAIL reset_out_sum: got %b expected 0000", out_sum); else passes++;
        checks++; if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", busy); else passes++;
    endtask

    // +3 +5 overflows positive.
    task automatic test_add_overflow();
        do_start(4'd2);
        checks++; if (in_ready !== 1'b1) $display("FAIL t1_in_ready: got %b expected 1", in_ready); else passes++;
        checks++; if (busy !== 1'b1) $display("FAIL t1_busy: got %b expected 1", busy); else passes++;
        send(4'd3, 1'b0);
        send(4'd5, 1'b0);
        checks++; if (out_valid !== 1'b1) $display("FAIL t1_out_valid: got %b expected 1", out_valid); else passes++;
        checks++; if (out_sum !== EXP_T1) $display("FAIL t1_out_sum: got %b expected %b", out_sum, EXP_T1); else passes++;
        checks++; if (out_ovf !== 1'b1) $display("FAIL t1_out_ovf: got %b expected 1", out_ovf); else passes++;
        drain();
    endtask

    // 6 - 3 with a two-cycle in_valid gap between the operands.
    task automatic test_sub_with_gap();
        do_start(4'd2);
        send(4'b0110, 1'b0);
        checks++; if (out_valid !== 1'b0) $display("FAIL t2_early_valid: got %b expected 0", out_valid); else passes++;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (in_ready !== 1'b1) $display("FAIL t2_gap_in_ready: got %b expected 1", in_ready); else passes++;
            checks++; if (out_valid !== 1'b0) $display("FAIL t2_gap_out_valid: got %b expected 0", out_valid); else passes++;
        end
        send(4'b0011, 1'b1);
        checks++; if (out_valid !== 1'b1) $display("FAIL t2_out_valid: got %b expected 1", out_valid); else passes++;
        checks++; if (out_sum !== 4'b0011) $display("FAIL t2_out_sum: got %b expected 0011", out_sum); else passes++;
        checks++; if (out_ovf !== 1'b0) $display("FAIL t2_out_ovf: got %b expected 0", out_ovf); else passes++;
        drain();
        checks++; if (busy !== 1'b0) $display("FAIL t2_busy_after: got %b expected 0", busy); else passes++;
    endtask

    // 7 +1 -1: overflow flag remains set after the total returns to range.
    task automatic test_sticky();
        do_start(4'd3);
        send(4'd7, 1'b0);
        send(4'd1, 1'b0);
        send(4'd1, 1'b1);
        checks++; if (out_valid !== 1'b1) $display("FAIL t3_out_valid: got %b expected 1", out_valid); else passes++;
        checks++; if (out_sum !== EXP_T3) $display("FAIL t3_out_sum: got %b expected %b", out_sum, EXP_T3); else passes++;
        checks++; if (out_ovf !== 1'b1) $display("FAIL t3_out_ovf: got %b expected 1", out_ovf); else passes++;
        drain();
    endtask

    // 0 - (-8) overflows; result held under backpressure, start ignored.
    task automatic test_backpressure();
        do_start(4'd1);
        send(4'b1000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            len   = 4'd5;
            checks++; if (out_valid !== 1'b1) $display("FAIL t4_out_valid[%0d]: got %b expected 1", i, out_valid); else passes++;
            checks++; if (out_sum !== EXP_T4) $display("FAIL t4_out_sum[%0d]: got %b expected %b", i, out_sum, EXP_T4); else passes++;
            checks++; if (out_ovf !== 1'b1) $display("FAIL t4_out_ovf[%0d]: got %b expected 1", i, out_ovf); else passes++;
            checks++; if (in_ready !== 1'b0) $display("FAIL t4_in_ready[%0d]: got %b expected 0", i, in_ready); else passes++;
            tick();
        end
        start = 1'b0;
        len   = 4'd0;
        checks++; if (out_valid !== 1'b1) $display("FAIL t4_hold_end: got %b expected 1", out_valid); else passes++;
        drain();
        checks++; if (busy !== 1'b0) $display("FAIL t4_busy_after: got %b expected 0", busy); else passes++;
    endtask

    task automatic test_zero_len();
        do_start(4'd0);
        checks++; if (out_valid !== 1'b1) $display("FAIL t5_out_valid: got %b expected 1", out_valid); else passes++;
        checks++; if (out_sum !== 4'b0000) $display("FAIL t5_out_sum: got %b expected 0000", out_sum); else passes++;
        checks++; if (out_ovf !== 1'b0) $display("FAIL t5_out_ovf: got %b expected 0", out_ovf); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL t5_in_ready: got %b expected 0", in_ready); else passes++;
        drain();
        checks++; if (busy !== 1'b0) $display("FAIL t5_busy: got %b expected 0", busy); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL t5_valid_after: got %b expected 0", out_valid); else passes++;
    endtask

    // Asynchronous reset mid-burst, then a fresh burst.
    task automatic test_reset_mid_run();
        do_start(4'd2);
        send(4'd5, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) $display("FAIL t6_in_ready: got %b expected 0", in_ready); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL t6_busy: got %b expected 0", busy); else passes++;
        checks++; if (out_sum !== 4'b0000) $display("FAIL t6_out_sum: got %b expected 0000", out_sum); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL t6_out_valid: got %b expected 0", out_valid); else passes++;
        checks++; if (out_ovf !== 1'b0) $display("FAIL t6_out_ovf: got %b expected 0", out_ovf); else passes++;
        tick();
        rst = 1'b0;
        tick();
        do_start(4'd1);
        send(4'b0001, 1'b0);
        checks++; if (out_valid !== 1'b1) $display("FAIL t6_new_valid: got %b expected 1", out_valid); else passes++;
        checks++; if (out_sum !== 4'b0001) $display("FAIL t6_new_sum: got %b expected 0001", out_sum); else passes++;
        checks++; if (out_ovf !== 1'b0) $display("FAIL t6_new_ovf: got %b expected 0", out_ovf); else passes++;
        drain();
    endtask

    // Next burst starts on the cycle right after the result handshake.
    task automatic test_back_to_back();
        do_start(4'd1);
        send(4'd2, 1'b0);
        drain();
        do_start(4'd1);
        checks++; if (in_ready !== 1'b1) $display("FAIL t7_in_ready: got %b expected 1", in_ready); else passes++;
        send(4'd1, 1'b1);
        checks++; if (out_sum !== 4'b1111) $display("FAIL t7_out_sum: got %b expected 1111", out_sum); else passes++;
        checks++; if (out_ovf !== 1'b0) $display("FAIL t7_out_ovf: got %b expected 0", out_ovf); else passes++;
        drain();
    endtask

    initial begin
        checks    = 0;
        passes    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        len       = 4'd0;
        in_valid  = 1'b0;
        in_data   = 4'd0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_add_overflow();
        test_sub_with_gap();
        test_sticky();
        test_backpressure();
        test_zero_len();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/addsub_accumulator.md
# addsub_accumulator

Sequential accumulator that sits directly downstream of the 4-bit adder/subtractor with overflow. It accepts a counted burst of signed operands through a valid/ready handshake and adds or subtracts each one into a running two's-complement total. At the end of the burst it presents the total and a sticky overflow flag on a second valid/ready handshake. The existing adder/subtractor is instantiated as the arithmetic core.

## Interface
- WIDTH, default 4: operand and accumulator width, signed two's complement.
- CNT_W, default 4: width of the burst-length field; maximum burst is 2^CNT_W-1 operands.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  pulse that begins a burst; sampled only in IDLE.
- len  in  CNT_W  number of operands in the burst; sampled with start.
- in_valid  in  1  operand present.
- in_ready  out  1  accumulator will take the operand this cycle.
- in_data  in  WIDTH  signed operand.
- in_sub  in  1  0 means acc + in_data; 1 means acc - in_data.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_sum  out  WIDTH  final accumulator value.
- out_ovf  out  1  sticky overflow flag for the burst.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE**
  - in_ready=0, out_valid=0.
  - start=1 with len>0: acc=0, ovf=0, remaining=len, go to RUN.
  - start=1 with len=0: acc=0, ovf=0, go directly to DONE.
- **RUN**
  - in_ready=1.
  - On in_valid&&in_ready: acc becomes the core result, ovf becomes ovf | core overflow, remaining decrements.
  - An accept with remaining==1 goes to DONE.
- **DONE**
  - out_valid=1, out_sum=acc, out_ovf=ovf.
  - out_ready=1 goes to IDLE.
- start is ignored in RUN and DONE.
- Core overflow rules:
  - Add: operand signs equal and result sign differs.
  - Sub: operand signs differ and result sign differs from acc.
- Wrap-around: without saturation the result is the low WIDTH bits of the exact sum.
- Stickiness: ovf stays set for the rest of the burst even if acc returns to range. It clears only on the next start or on reset.

## Timing
- Reset values: state=IDLE, acc=0, ovf=0, remaining=0, in_ready=0, out_valid=0, out_sum=0, out_ovf=0, busy=0.
- in_ready, out_valid and busy decode from the registered state only. They have no combinational path from in_valid or out_ready.
- Throughput is one operand per clock in RUN.
- Result latency: out_valid rises on the clock edge that accepts the last operand, and is visible the following cycle.
- len=0: out_valid is visible one cycle after start.
- While out_valid=1 and out_ready=0, out_sum and out_ovf hold stable.
- Back-to-back bursts: the earliest next start is sampled the cycle after the DONE→IDLE handshake.
- Reset asserted mid-RUN or mid-DONE returns every output to its reset value immediately (asynchronously). The partial burst is discarded.

## Configuration
- Macro ADDSUB_ACC_SATURATE_EN.
- Defined: on a step that overflows, acc clamps instead of wrapping.
  - Positive overflow clamps to the maximum positive value (0111 for WIDTH=4).
  - Negative overflow clamps to the minimum negative value (1000).
  - ovf is still set.
- Undefined: acc wraps. The clamp logic is absent.

## Structure
- Shared package addsub_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - the localparams for the signed max and min values derived from WIDTH;
  - the default WIDTH.
- One sub-module, addsub_core: the combinational WIDTH-bit adder/subtractor with overflow, with ports a, b, sel, result, overflow. The accumulator instantiates it with a=acc, b=in_data, sel=in_sub.
- Saturation muxing lives in addsub_accumulator, not in the core.

## Test plan
- start len=2; operands +3 add, +5 add → out_sum=1000, out_ovf=1. With ADDSUB_ACC_SATURATE_EN: out_sum=0111.
- start len=2; operands 0110 add, 0011 sub → out_sum=0011, out_ovf=0. out_valid is visible the cycle after the second accept.
- start len=3; operands +7 add, +1 add, +1 sub → out_sum=0111, out_ovf=1, showing the sticky flag.
  - The arithmetic is 7→8 (wraps to 1000)→7.
  - With saturation the steps are 7→7→6, giving out_sum=0110, out_ovf=1.
- Backpressure and framing:
  - start len=1; operand 0000 sub 1000 → out_sum=1000, out_ovf=1.
  - Hold out_ready=0 for 3 cycles: out_valid, out_sum and out_ovf are stable, in_ready=0, and a start pulse in DONE is ignored.
  - Drop in_valid for 2 cycles mid-RUN: no accept occurs and acc is unchanged.
- start len=0 → out_valid=1 the next cycle with out_sum=0000, out_ovf=0. out_ready=1 returns to IDLE with busy=0.
- Assert rst in RUN after one of two operands → all outputs 0 immediately. A new burst len=1, operand 0001 add, yields out_sum=0001, out_ovf=0.
